cond_branch_unit: RTL and testbench

COND_BRANCH_UNIT -- requirements
Module: cond_branch_unit

---
 rtl/cond_branch_unit.sv | 139 +++++++++++++
 tb/tb_cond_branch_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cond_branch_unit.sv
// Conditional branch resolver: holds the committed NZCV flags, evaluates branches and issues fetch redirects.
// Optional feature macro: COND_FWD_EN forwards same-cycle ALU flags into branch evaluation instead of stalling.
module cond_branch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        flag_we,
  input  logic        flag_n,
  input  logic        flag_z,
  input  logic        flag_c,
  input  logic        flag_v,
  input  logic        br_valid,
  input  logic [3:0]  br_cond,
  input  logic [63:0] br_target,
  output logic        br_ready,
  output logic        redir_valid,
  output logic [63:0] redir_target,
  input  logic        redir_ready,
  output logic        stall,
  output logic [3:0]  cpsr,
  output logic [15:0] taken_cnt
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_FLAGS = 2'd1,
    S_REDIRECT   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cpsr_q, cpsr_d;
  logic [3:0]  cond_q, cond_d;
  logic [63:0] target_q, target_d;
  logic [15:0] taken_cnt_q, taken_cnt_d;
  logic        taken_s;
  logic [3:0]  flags_in_s;

  // Flags are packed {N,Z,C,V}; unlisted condition codes are never taken.
  function automatic logic cond_met(input logic [3:0] cond, input logic [3:0] f);
    case (cond)
      4'b0000: cond_met = f[2];
      4'b0001: cond_met = ~f[2];
      4'b1000: cond_met = f[1] & ~f[2];
      4'b1011: cond_met = f[3] ^ f[0];
      4'b1110: cond_met = 1'b1;
      default: cond_met = 1'b0;
    endcase
  endfunction

  assign flags_in_s = {flag_n, flag_z, flag_c, flag_v};

  // Next-state, flag commit, branch capture and taken-count logic.
  always_comb begin
    state_d     = state_q;
    cond_d      = cond_q;
    target_d    = target_q;
    taken_s     = 1'b0;
    if (flag_we) begin
      cpsr_d = flags_in_s;
    end else begin
      cpsr_d = cpsr_q;
    end
    case (state_q)
      S_IDLE: begin
        if (br_valid) begin
          cond_d = br_cond;
`ifdef COND_FWD_EN
          if (cond_met(br_cond, flag_we ? flags_in_s : cpsr_q)) begin
            state_d  = S_REDIRECT;
            target_d = br_target;
            taken_s  = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
`else
          // Flags are still in flight: park the branch for one cycle.
          if (flag_we) begin
            state_d  = S_WAIT_FLAGS;
            target_d = br_target;
          end else if (cond_met(br_cond, cpsr_q)) begin
            state_d  = S_REDIRECT;
            target_d = br_target;
            taken_s  = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_FLAGS: begin
        if (cond_met(cond_q, cpsr_q)) begin
          state_d = S_REDIRECT;
          taken_s = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REDIRECT: begin
        if (redir_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_REDIRECT;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (taken_s && (taken_cnt_q != 16'hFFFF)) begin
      taken_cnt_d = taken_cnt_q + 16'd1;
    end else begin
      taken_cnt_d = taken_cnt_q;
    end
  end

  // State and data registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cpsr_q      <= 4'd0;
      cond_q      <= 4'd0;
      target_q    <= 64'd0;
      taken_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cpsr_q      <= cpsr_d;
      cond_q      <= cond_d;
      target_q    <= target_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign br_ready     = (state_q == S_IDLE);
  assign stall        = (state_q != S_IDLE);
  assign redir_valid  = (state_q == S_REDIRECT);
  assign redir_target = target_q;
  assign cpsr         = cpsr_q;
  assign taken_cnt    = taken_cnt_q;

endmodule

// File: tb/tb_cond_branch_unit.sv
// Directed self-checking bench for cond_branch_unit; expectations follow COND_FWD_EN when it is defined.
module tb_cond_branch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flag_we;
  logic        flag_n, flag_z, flag_c, flag_v;
  logic        br_valid;
  logic [3:0]  br_cond;
  logic [63:0] br_target;
  logic        br_ready;
  logic        redir_valid;
  logic [63:0] redir_target;
  logic        redir_ready;
  logic        stall;
  logic [3:0]  cpsr;
  logic [15:0] taken_cnt;

  int vectors = 0;
  int miscompares = 0;

  cond_branch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .flag_we      (flag_we),
    .flag_n       (flag_n),
    .flag_z       (flag_z),
    .flag_c       (flag_c),
    .flag_v       (flag_v),
    .br_valid     (br_valid),
    .br_cond      (br_cond),
    .br_target    (br_target),
    .br_ready     (br_ready),
    .redir_valid  (redir_valid),
    .redir_target (redir_target),
    .redir_ready  (redir_ready),
    .stall        (stall),
    .cpsr         (cpsr),
    .taken_cnt    (taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_flags(input logic we, input logic [3:0] nzcv);
    flag_we = we;
    {flag_n, flag_z, flag_c, flag_v} = nzcv;
  endtask

  task automatic offer(input logic v, input logic [3:0] c, input logic [63:0] t);
    br_valid  = v;
    br_cond   = c;
    br_target = t;
  endtask

  initial begin
    rst = 1'b1;
    redir_ready = 1'b1;
    set_flags(1'b0, 4'b0000);
    offer(1'b0, 4'b0000, 64'd0);
    tick();
    tick();
    rst = 1'b0;
    chk("rst_redir_valid", 64'(redir_valid), 64'd0);
    chk("rst_redir_target", redir_target, 64'd0);
    chk("rst_cpsr", 64'(cpsr), 64'd0);
    chk("rst_taken_cnt", 64'(taken_cnt), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_br_ready", 64'(br_ready), 64'd1);

    // Z=1, EQ taken directly
    set_flags(1'b1, 4'b0100);
    tick();
    set_flags(1'b0, 4'b0000);
    chk("cpsr_z", 64'(cpsr), 64'h4);
    offer(1'b1, 4'b0000, 64'h1000);
    tick();
    offer(1'b0, 4'b0000, 64'd0);
    chk("eq_redir_valid", 64'(redir_valid), 64'd1);
    chk("eq_redir_target", redir_target, 64'h1000);
    chk("eq_taken_cnt", 64'(taken_cnt), 64'd1);
    chk("eq_br_ready", 64'(br_ready), 64'd0);
    tick();
    chk("eq_done_valid", 64'(redir_valid), 64'd0);
    chk("eq_done_ready", 64'(br_ready), 64'd1);

    // Z=1, NE not taken
    offer(1'b1, 4'b0001, 64'h1100);
    tick();
    offer(1'b0, 4'b0000, 64'd0);
    chk("ne_redir_valid", 64'(redir_valid), 64'd0);
    chk("ne_stall", 64'(stall), 64'd0);
    chk("ne_taken_cnt", 64'(taken_cnt), 64'd1);

    // C=1 Z=0, HI taken; undefined code never taken
    set_flags(1'b1, 4'b0010);
    tick();
    set_flags(1'b0, 4'b0000);
    offer(1'b1, 4'b1000, 64'h3000);
    tick();
    offer(1'b0, 4'b0000, 64'd0);
    chk("hi_redir_valid", 64'(redir_valid), 64'd1);
    chk("hi_redir_target", redir_target, 64'h3000);
    chk("hi_taken_cnt", 64'(taken_cnt), 64'd2);
    tick();
    offer(1'b1, 4'b0111, 64'h3100);
    tick();
    offer(1'b0, 4'b0000, 64'd0);
    chk("undef_redir_valid", 64'(redir_valid), 64'd0);
    chk("undef_taken_cnt", 64'(taken_cnt), 64'd2);

    // flag_we N=1 V=0 with LT in the same cycle (cpsr alone says not-taken)
    set_flags(1'b1, 4'b1000);
    offer(1'b1, 4'b1011, 64'h2000);
    tick();
    set_flags(1'b0, 4'b0000);
    offer(1'b0, 4'b0000, 64'd0);
    chk("lt_cpsr", 64'(cpsr), 64'h8);
`ifdef COND_FWD_EN
    chk("lt_fwd_redir_valid", 64'(redir_valid), 64'd1);
`else
    chk("lt_wait_redir_valid", 64'(redir_valid), 64'd0);
    chk("lt_wait_stall", 64'(stall), 64'd1);
    chk("lt_wait_br_ready", 64'(br_ready), 64'd0);
    tick();
    chk("lt_redir_valid", 64'(redir_valid), 64'd1);
`endif
    chk("lt_redir_target", redir_target, 64'h2000);
    chk("lt_taken_cnt", 64'(taken_cnt), 64'd3);
    tick();
    chk("lt_done_valid", 64'(redir_valid), 64'd0);

    // cpsr says LT taken, but same-cycle flags N=1 V=1 make it not-taken
    set_flags(1'b1, 4'b1001);
    offer(1'b1, 4'b1011, 64'h2200);
    tick();
    set_flags(1'b0, 4'b0000);
    offer(1'b0, 4'b0000, 64'd0);
    chk("ltn_redir_valid", 64'(redir_valid), 64'd0);
`ifdef COND_FWD_EN
    chk("ltn_stall", 64'(stall), 64'd0);
`else
    chk("ltn_stall", 64'(stall), 64'd1);
`endif
    tick();
    chk("ltn_redir_valid2", 64'(redir_valid), 64'd0);
    chk("ltn_stall2", 64'(stall), 64'd0);
    chk("ltn_taken_cnt", 64'(taken_cnt), 64'd3);

    // AL held by backpressure; second offer must be ignored
    redir_ready = 1'b0;
    offer(1'b1, 4'b1110, 64'h4000);
    tick();
    offer(1'b1, 4'b1110, 64'h5000);
    for (int i = 0; i < 3; i++) begin
      chk("hold_redir_valid", 64'(redir_valid), 64'd1);
      chk("hold_redir_target", redir_target, 64'h4000);
      chk("hold_br_ready", 64'(br_ready), 64'd0);
      tick();
    end
    chk("hold_taken_cnt", 64'(taken_cnt), 64'd4);
    offer(1'b0, 4'b0000, 64'd0);
    redir_ready = 1'b1;
    tick();
    chk("hold_done_valid", 64'(redir_valid), 64'd0);
    chk("hold_done_cnt", 64'(taken_cnt), 64'd4);

    // Saturation: preload near the top, then three AL branches
    @(negedge clk);
    force dut.taken_cnt_q = 16'hFFFD;
    #1;
    release dut.taken_cnt_q;
    offer(1'b1, 4'b1110, 64'h6000);
    tick();
    offer(1'b0, 4'b0000, 64'd0);
    chk("sat_cnt_fffe", 64'(taken_cnt), 64'hFFFE);
    tick();
    offer(1'b1, 4'b1110, 64'h6000);
    tick();
    offer(1'b0, 4'b0000, 64'd0);
    chk("sat_cnt_ffff", 64'(taken_cnt), 64'hFFFF);
    tick();
    offer(1'b1, 4'b1110, 64'h6000);
    tick();
    offer(1'b0, 4'b0000, 64'd0);
    chk("sat_cnt_hold", 64'(taken_cnt), 64'hFFFF);
    tick();

    // Reset mid-REDIRECT, with flag_we and a branch offered in the reset cycle
    redir_ready = 1'b0;
    offer(1'b1, 4'b1110, 64'h7000);
    tick();
    chk("pre_rst_redir_valid", 64'(redir_valid), 64'd1);
    rst = 1'b1;
    set_flags(1'b1, 4'b1111);
    tick();
    rst = 1'b0;
    set_flags(1'b0, 4'b0000);
    offer(1'b0, 4'b0000, 64'd0);
    chk("mid_rst_redir_valid", 64'(redir_valid), 64'd0);
    chk("mid_rst_cpsr", 64'(cpsr), 64'd0);
    chk("mid_rst_taken_cnt", 64'(taken_cnt), 64'd0);
    chk("mid_rst_br_ready", 64'(br_ready), 64'd1);
    chk("mid_rst_target", redir_target, 64'd0);
    tick();
    chk("post_rst_redir_valid", 64'(redir_valid), 64'd0);

    // Reset right after an acceptance with same-cycle flags (WAIT_FLAGS in the default build)
    redir_ready = 1'b1;
    set_flags(1'b1, 4'b0000);
    offer(1'b1, 4'b0001, 64'h8000);
    tick();
    set_flags(1'b0, 4'b0000);
    offer(1'b0, 4'b0000, 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("wait_rst_redir_valid", 64'(redir_valid), 64'd0);
    chk("wait_rst_taken_cnt", 64'(taken_cnt), 64'd0);
    chk("wait_rst_stall", 64'(stall), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
